kogge_stone_pipe: RTL

KOGGE_STONE_PIPE -- requirements
Module: kogge_stone_pipe

---
 rtl/ks_pkg.sv | 27 ++
 rtl/ks_prefix_level.sv | 26 ++
 rtl/kogge_stone_pipe.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ks_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Kogge-Stone adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: mode_e (ADD/SUB), log2_levels(width), num_stages(width, levels_per_stage).
package ks_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Number of Kogge-Stone prefix levels for a power-of-two width.
  function automatic int log2_levels(input int w);
    int n;
    n = 0;
    while ((1 << n) < w) n++;
    return n;
  endfunction

  // Prefix pipeline stages when each stage holds up to 'sl' levels.
  function automatic int num_stages(input int w, input int sl);
    int lv;
    lv = log2_levels(w);
    return (lv + sl - 1) / sl;
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level at combine distance DIST.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline registers handle stalls.
// Ports: g_in/p_in incoming group generate/propagate, g_out/p_out combined groups.
module ks_prefix_level #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : bit_g
    if (i >= DIST) begin : comb
      assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
      assign p_out[i] = p_in[i] & p_in[i-DIST];
    end else begin : pass
      // Low bits already span down to the carry-in; nothing left to combine.
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end
  end

endmodule

// File: rtl/kogge_stone_pipe.sv
// Pipelined Kogge-Stone add/subtract with valid/ready handshake on both sides.
// Latency: NS+1 edges from accept to out_valid (NS = ceil(log2(WIDTH)/STAGE_LEVELS)).
// Backpressure: global enable; a stalled output freezes every stage and drops in_ready.
// Ports: in_valid/in_ready + a, b, cin, mode (0 ADD, 1 SUB) in; out_valid/out_ready + sum, cout out.
// Optional: define KOGGE_STONE_PIPE_OVF_EN to add output ovf (signed overflow, aligned with sum).
module kogge_stone_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STAGE_LEVELS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef KOGGE_STONE_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int LV = log2_levels(WIDTH);
  localparam int NS = num_stages(WIDTH, STAGE_LEVELS);

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Operand preparation: subtraction is a + ~b + 1.
  mode_e            md;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] p0;
  logic             cin_eff;

  assign md      = mode_e'(mode);
  assign bx      = (md == MODE_SUB) ? ~b : b;
  assign cin_eff = (md == MODE_SUB) ? 1'b1 : cin;
  assign g0      = a & bx;
  assign p0      = a ^ bx;

  // Stage registers. gv/pv are the prefix vectors shifted up one place so that
  // index 0 holds the carry-in as bit -1; index j then resolves to the carry
  // into bit j. The top bit's g/p stay outside the tree (gm, p[WIDTH-1]) and
  // are folded in at the sum stage to form cout.
  for (genvar s = 0; s < NS; s++) begin : stg
    logic             vld;
    logic [WIDTH-1:0] gv;
    logic [WIDTH-1:0] pv;
    logic [WIDTH-1:0] p;
    logic             gm;

    logic             vld_d;
    logic [WIDTH-1:0] gv_d;
    logic [WIDTH-1:0] pv_d;
    logic [WIDTH-1:0] p_d;
    logic             gm_d;

    if (s == 0) begin : src
      assign vld_d = in_valid;
      assign gv_d  = {g0[WIDTH-2:0], cin_eff};
      assign pv_d  = {p0[WIDTH-2:0], 1'b0};
      assign p_d   = p0;
      assign gm_d  = g0[WIDTH-1];
    end else begin : chain
      assign vld_d = stg[s-1].vld;
      assign gv_d  = lvl[s*STAGE_LEVELS-1].go;
      assign pv_d  = lvl[s*STAGE_LEVELS-1].po;
      assign p_d   = stg[s-1].p;
      assign gm_d  = stg[s-1].gm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= 1'b0;
      end else if (en) begin
        vld <= vld_d;
      end
    end

    always_ff @(posedge clk) begin
      if (en) begin
        gv <= gv_d;
        pv <= pv_d;
        p  <= p_d;
        gm <= gm_d;
      end
    end
  end

  // Prefix levels: the first level of each stage reads that stage's register,
  // the rest chain combinationally from the previous level.
  for (genvar k = 0; k < LV; k++) begin : lvl
    logic [WIDTH-1:0] gi;
    logic [WIDTH-1:0] pi;
    logic [WIDTH-1:0] go;
    logic [WIDTH-1:0] po;

    if ((k % STAGE_LEVELS) == 0) begin : from_reg
      assign gi = stg[k/STAGE_LEVELS].gv;
      assign pi = stg[k/STAGE_LEVELS].pv;
    end else begin : from_lvl
      assign gi = lvl[k-1].go;
      assign pi = lvl[k-1].po;
    end

    ks_prefix_level #(
      .WIDTH(WIDTH),
      .DIST (1 << k)
    ) u_level (
      .g_in (gi),
      .p_in (pi),
      .g_out(go),
      .p_out(po)
    );
  end

  // Sum stage shares the last prefix stage's cycle so the output register is
  // the final pipeline bank.
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             fin_vld;
  logic             unused_p;

  assign carry    = lvl[LV-1].go;
  assign fin_vld  = stg[NS-1].vld;
  assign sum_d    = stg[NS-1].p ^ carry;
  assign cout_d   = stg[NS-1].gm | (stg[NS-1].p[WIDTH-1] & carry[WIDTH-1]);
  // Full-span propagate includes the zero at bit -1, so it carries no information.
  assign unused_p = ^lvl[LV-1].po;

`ifdef KOGGE_STONE_PIPE_OVF_EN
  logic ovf_d;
  assign ovf_d = carry[WIDTH-1] ^ cout_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef KOGGE_STONE_PIPE_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (en) begin
      out_valid <= fin_vld;
      // Bubbles leave the previous result in place.
      if (fin_vld) begin
        sum  <= sum_d;
        cout <= cout_d;
`ifdef KOGGE_STONE_PIPE_OVF_EN
        ovf  <= ovf_d;
`endif
      end
    end
  end

endmodule
